// File: rtl/ccd_pkg.sv
// Shared CCD acquisition/packer types and constants.
// Pixel count here is also used by the acquisition stage.
package ccd_pkg;

  localparam int unsigned CCD_PIXELS = 1024;
  localparam logic [7:0]  CCD_SYNC0  = 8'hA5;
  localparam logic [7:0]  CCD_SYNC1  = 8'h5A;

  typedef enum logic [3:0] {
    P_IDLE,
    P_HDR0,
    P_HDR1,
    P_CNT,
    P_LENH,
    P_LENL,
    P_RDREQ,
    P_RDWAIT,
    P_PIX,
    P_CSUM,
    P_DONE
  } packer_state_t;

  function automatic logic [7:0] csum_add(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc + b;
  endfunction

endpackage

// File: rtl/byte_tx_hold.sv
// Byte output register: holds tx_data/tx_valid until the sink accepts.
// Shared with the UART transmitter front end.
module byte_tx_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (tx_valid & tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ccd_frame_packer.sv
// Drains one pixel line from the FIFO into a sync/cnt/len/pixels packet.
// Define CCD_PACKER_CHECKSUM_EN to append a mod-256 checksum byte.
module ccd_frame_packer
  import ccd_pkg::*;
#(
  parameter int unsigned PIXELS = CCD_PIXELS,
  parameter logic [7:0]  SYNC0  = CCD_SYNC0,
  parameter logic [7:0]  SYNC1  = CCD_SYNC1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] fifo_q,
  input  logic       fifo_rdempty,
  output logic       fifo_rdreq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       overrun
);

  localparam logic [15:0] LEN = 16'(PIXELS);

  packer_state_t state;
  packer_state_t state_nxt;

  logic        fs_d;
  logic        start;
  logic        accept;
  logic        load;
  logic [7:0]  load_data;
  logic [15:0] pix_cnt;
  logic [15:0] pix_inc;
  logic        last_pix;

  assign start    = frame_start & ~fs_d;
  assign accept   = tx_valid & tx_ready;
  assign pix_inc  = pix_cnt + 16'd1;
  assign last_pix = !(pix_inc < LEN);

`ifdef CCD_PACKER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_out;
  logic       csum_byte;

  assign csum_byte = (state == P_CNT)
                  || (state == P_LENH)
                  || (state == P_LENL)
                  || (state == P_PIX);
  // Final value folds in the pixel being accepted this cycle.
  assign csum_out = csum_add(csum, tx_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (state == P_IDLE) begin
      csum <= 8'h00;
    end else if (accept && csum_byte) begin
      csum <= csum_add(csum, tx_data);
    end
  end
`endif

  byte_tx_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= P_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      P_IDLE:   if (start)  state_nxt = P_HDR0;
      P_HDR0:   if (accept) state_nxt = P_HDR1;
      P_HDR1:   if (accept) state_nxt = P_CNT;
      P_CNT:    if (accept) state_nxt = P_LENH;
      P_LENH:   if (accept) state_nxt = P_LENL;
      P_LENL:   if (accept) state_nxt = P_RDREQ;
      P_RDREQ:  if (!fifo_rdempty) state_nxt = P_RDWAIT;
      P_RDWAIT: state_nxt = P_PIX;
      P_PIX: begin
        if (accept) begin
          if (!last_pix) begin
            state_nxt = P_RDREQ;
          end else begin
`ifdef CCD_PACKER_CHECKSUM_EN
            state_nxt = P_CSUM;
`else
            state_nxt = P_DONE;
`endif
          end
        end
      end
`ifdef CCD_PACKER_CHECKSUM_EN
      P_CSUM:   if (accept) state_nxt = P_DONE;
`endif
      P_DONE:   state_nxt = P_IDLE;
      default:  state_nxt = P_IDLE;
    endcase
  end

  // Each byte is loaded on the edge that enters the state sending it.
  always_comb begin
    busy       = (state != P_IDLE);
    fifo_rdreq = 1'b0;
    load       = 1'b0;
    load_data  = tx_data;
    unique case (state)
      P_IDLE: begin
        load      = start;
        load_data = SYNC0;
      end
      P_HDR0: begin
        load      = accept;
        load_data = SYNC1;
      end
      P_HDR1: begin
        load      = accept;
        load_data = frame_cnt;
      end
      P_CNT: begin
        load      = accept;
        load_data = LEN[15:8];
      end
      P_LENH: begin
        load      = accept;
        load_data = LEN[7:0];
      end
      P_RDREQ: begin
        fifo_rdreq = !fifo_rdempty;
      end
      P_RDWAIT: begin
        load      = 1'b1;
        load_data = fifo_q;
      end
      P_PIX: begin
`ifdef CCD_PACKER_CHECKSUM_EN
        load      = accept && last_pix;
        load_data = csum_out;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_d      <= 1'b0;
      pix_cnt   <= 16'd0;
      frame_cnt <= 8'd0;
      overrun   <= 1'b0;
    end else begin
      fs_d <= frame_start;
      if (state == P_LENL) begin
        pix_cnt <= 16'd0;
      end else if (state == P_PIX && accept) begin
        pix_cnt <= pix_inc;
      end
      if (state == P_DONE) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (start && state != P_IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccd_frame_packer.sv
// Directed bench for ccd_frame_packer with a 4-pixel line.
// Expected streams are built from hand-picked pixel constants.
module tb_ccd_frame_packer;

  localparam int NPIX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rdempty;
  logic       fifo_rdreq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;

  logic [7:0] rx [0:8191];
  int         rx_n     = 0;
  int         hold_err = 0;
  int         rd_err   = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [7:0] exp_b [0:15];
  int         exp_n;

  always #5 clk = ~clk;

  ccd_frame_packer #(.PIXELS(NPIX)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .overrun      (overrun)
  );

  assign fifo_rdempty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rdreq && !fifo_rdempty) begin
      fifo_q <= mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_err++;
      if (fifo_rdreq && fifo_rdempty) rd_err++;
      if (tx_valid && tx_ready) begin
        rx[rx_n] = tx_data;
        rx_n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push4(input logic [7:0] a, b, c, d);
    push(a);
    push(b);
    push(c);
    push(d);
  endtask

  task automatic pulse_start;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (busy && cyc < budget) begin
      cyc++;
      tick();
    end
    ok = !busy;
  endtask

  task automatic build_exp(input logic [7:0] cnt, input logic [7:0] a, b, c, d);
    logic [7:0] s;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h5A;
    exp_b[2] = cnt;
    exp_b[3] = 8'h00;
    exp_b[4] = 8'h04;
    exp_b[5] = a;
    exp_b[6] = b;
    exp_b[7] = c;
    exp_b[8] = d;
    exp_n = 9;
`ifdef CCD_PACKER_CHECKSUM_EN
    s = cnt + 8'h00 + 8'h04 + a + b + c + d;
    exp_b[9] = s;
    exp_n = 10;
`else
    s = 8'h00;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    frame_start = 1'b0;
    tx_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (frame_cnt !== 8'h00) begin bad++; $display("FAIL rst_frame_cnt got %h want 00", frame_cnt); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
    total++; if (fifo_rdreq !== 1'b0) begin bad++; $display("FAIL rst_rdreq got %b want 0", fifo_rdreq); end
  endtask

  task automatic test_basic;
    int base, cyc, want_cyc;
    bit ok;
    base = rx_n;
    build_exp(8'h00, 8'h01, 8'h02, 8'h03, 8'h04);
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    tx_ready = 1'b1;
    pulse_start();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL start_latency got v=%b d=%h want v=1 d=a5", tx_valid, tx_data);
    end
    wait_idle(200, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got busy want idle"); end
    want_cyc = 5 + 3 * NPIX + 1 + (exp_n - 9);
    total++; if (cyc != want_cyc) begin bad++; $display("FAIL basic_cycles got %0d want %0d", cyc, want_cyc); end
    total++; if (rx_n - base != exp_n) begin bad++; $display("FAIL basic_len got %0d want %0d", rx_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++; if (rx[base + k] !== exp_b[k]) begin
        bad++; $display("FAIL basic_byte%0d got %h want %h", k, rx[base + k], exp_b[k]);
      end
    end
    total++; if (frame_cnt !== 8'h01) begin bad++; $display("FAIL basic_frame_cnt got %h want 01", frame_cnt); end
  endtask

  task automatic test_random_ready;
    int base, cyc;
    base = rx_n;
    build_exp(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    frame_start = 1'b1;
    tx_ready = 1'($urandom_range(0, 1));
    tick();
    frame_start = 1'b0;
    cyc = 0;
    while (busy && cyc < 600) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    total++; if (busy) begin bad++; $display("FAIL rand_timeout got busy want idle"); end
    total++; if (rx_n - base != exp_n) begin bad++; $display("FAIL rand_len got %0d want %0d", rx_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++; if (rx[base + k] !== exp_b[k]) begin
        bad++; $display("FAIL rand_byte%0d got %h want %h", k, rx[base + k], exp_b[k]);
      end
    end
    total++; if (hold_err != 0) begin bad++; $display("FAIL rand_hold got %0d want 0", hold_err); end
    total++; if (frame_cnt !== 8'h02) begin bad++; $display("FAIL rand_frame_cnt got %h want 02", frame_cnt); end
  endtask

  task automatic test_fifo_empty;
    int base, cyc, low;
    bit ok;
    base = rx_n;
    build_exp(8'h02, 8'h55, 8'h66, 8'h77, 8'h88);
    push(8'h55);
    push(8'h66);
    pulse_start();
    repeat (30) tick();
    low = 0;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid && busy && !fifo_rdreq) low++;
    end
    total++; if (low != 50) begin bad++; $display("FAIL empty_stall got %0d want 50", low); end
    total++; if (rx_n - base != 7) begin bad++; $display("FAIL empty_partial got %0d want 7", rx_n - base); end
    tick();
    push(8'h77);
    push(8'h88);
    wait_idle(200, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_timeout got busy want idle"); end
    total++; if (rx_n - base != exp_n) begin bad++; $display("FAIL empty_len got %0d want %0d", rx_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++; if (rx[base + k] !== exp_b[k]) begin
        bad++; $display("FAIL empty_byte%0d got %h want %h", k, rx[base + k], exp_b[k]);
      end
    end
    total++; if (frame_cnt !== 8'h03) begin bad++; $display("FAIL empty_frame_cnt got %h want 03", frame_cnt); end
  endtask

  task automatic test_overrun;
    int base, cyc;
    bit ok;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre got %b want 0", overrun); end
    base = rx_n;
    build_exp(8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    push4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    pulse_start();
    repeat (8) tick();
    pulse_start();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", overrun); end
    wait_idle(200, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_timeout got busy want idle"); end
    for (int k = 0; k < exp_n; k++) begin
      total++; if (rx[base + k] !== exp_b[k]) begin
        bad++; $display("FAIL ovr_byte%0d got %h want %h", k, rx[base + k], exp_b[k]);
      end
    end
    repeat (40) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_second_busy got %b want 0", busy); end
    total++; if (rx_n - base != exp_n) begin bad++; $display("FAIL ovr_len got %0d want %0d", rx_n - base, exp_n); end
    total++; if (frame_cnt !== 8'h04) begin bad++; $display("FAIL ovr_frame_cnt got %h want 04", frame_cnt); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back;
    int base, cyc;
    bit ok;
    logic [7:0] cnt;
    logic [7:0] v;
    cnt = 8'h04;
    for (int i = 0; i < 256; i++) begin
      base = rx_n;
      v = 8'(i);
      push4(v, v + 8'd1, v + 8'd2, v + 8'd3);
      pulse_start();
      wait_idle(200, cyc, ok);
      total++; if (!ok || rx[base + 2] !== cnt) begin
        bad++; $display("FAIL b2b_cnt%0d got %h want %h", i, rx[base + 2], cnt);
      end
      cnt = cnt + 8'd1;
    end
    total++; if (frame_cnt !== 8'h04) begin bad++; $display("FAIL b2b_wrap got %h want 04", frame_cnt); end
    total++; if (rd_err != 0) begin bad++; $display("FAIL rdreq_empty got %0d want 0", rd_err); end
  endtask

  task automatic test_reset_mid;
    int base, cyc;
    bit ok;
    push4(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    pulse_start();
    repeat (10) tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
    total++; if (frame_cnt !== 8'h00) begin bad++; $display("FAIL mid_frame_cnt got %h want 00", frame_cnt); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun got %b want 0", overrun); end
    total++; if (fifo_rdreq !== 1'b0) begin bad++; $display("FAIL mid_rdreq got %b want 0", fifo_rdreq); end
    tick();
    rst = 1'b0;
    wr_ptr = rd_ptr;
    tick();
    base = rx_n;
    build_exp(8'h00, 8'hF1, 8'hF2, 8'hF3, 8'hF4);
    push4(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    pulse_start();
    wait_idle(200, cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout got busy want idle"); end
    total++; if (rx_n - base != exp_n) begin bad++; $display("FAIL mid_len got %0d want %0d", rx_n - base, exp_n); end
    for (int k = 0; k < exp_n; k++) begin
      total++; if (rx[base + k] !== exp_b[k]) begin
        bad++; $display("FAIL mid_byte%0d got %h want %h", k, rx[base + k], exp_b[k]);
      end
    end
    total++; if (frame_cnt !== 8'h01) begin bad++; $display("FAIL mid_frame_cnt_after got %h want 01", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_fifo_empty();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
